// File: rtl/psram_pkg.sv
// psram_pkg: shared command codes, address width and state encoding for the PSRAM link.
package psram_pkg;
   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;
   localparam logic [7:0] CMD_WRITE     = 8'h02;
   localparam int         ADDR_BITS     = 24;
   typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE} psram_state_e;
   function automatic logic cmd_valid(logic [7:0] c);
      return c == CMD_READ || c == CMD_FAST_READ || c == CMD_WRITE;
   endfunction
endpackage

// File: rtl/psram_responder_if.sv
// psram_responder_if: pin-level serial PSRAM bus between host and device.
interface psram_responder_if;
   logic ce_n;
   logic sclk;
   logic si;
   logic so;
   logic so_oe;
   modport master (output ce_n, sclk, si, input so, so_oe);
   modport slave  (input ce_n, sclk, si, output so, so_oe);
endinterface

// File: rtl/psram_resp_mem.sv
// psram_resp_mem: single-port byte RAM with registered read, maps to block RAM.
module psram_resp_mem #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [7:0]    wdata_i,
   output logic [7:0]    rdata_o
);
   logic [7:0] mem_q [2**AW];
   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_o <= mem_q[addr_i];
   end
endmodule

// File: rtl/psram_responder.sv
// psram_responder: SPI-mode PSRAM target emulator, oversampling the serial bus on clk.
module psram_responder
   import psram_pkg::*;
#(
   parameter int MEM_ADDR_W  = 12,
   parameter int FAST_WAIT   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   psram_responder_if.slave   bus,
   output logic               busy,
   output logic               cmd_err
);
   localparam int S  = SYNC_STAGES;
   localparam int AW = MEM_ADDR_W;
   psram_state_e  state_q, state_d;
   logic [S:0]    ce_q, sclk_q;
   logic [S-1:0]  si_q;
   logic [7:0]    cnt_q, cnt_d, cmd_q, cmd_d, rx_q, rx_d, tx_q, tx_d, rx_nxt, mem_rdata;
   logic [AW-1:0] addr_q, addr_d, mem_addr;
   logic          so_q, so_d, oe_q, oe_d, busy_q, busy_d, err_q, err_d, ld_q, ld_d, we;
   logic          ce_fall, ce_rise, s_rise, s_fall, si_s;
   // ce_n chain clears to 0 so a frame already in progress at reset release never looks like a start
   always_ff @(posedge clk) begin
      if (rst) begin
         ce_q   <= '0;
         sclk_q <= '0;
         si_q   <= '0;
      end else begin
         ce_q   <= {ce_q[S-1:0], bus.ce_n};
         sclk_q <= {sclk_q[S-1:0], bus.sclk};
         si_q   <= {si_q[S-2:0], bus.si};
      end
   end
   assign ce_fall = ce_q[S] & ~ce_q[S-1];
   assign ce_rise = ~ce_q[S] & ce_q[S-1];
   assign s_rise  = ~sclk_q[S] & sclk_q[S-1] & ~ce_rise;
   assign s_fall  = sclk_q[S] & ~sclk_q[S-1] & ~ce_rise;
   assign si_s    = si_q[S-1];
   assign rx_nxt  = {rx_q[6:0], si_s};
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cmd_q   <= '0;
         rx_q    <= '0;
         tx_q    <= '0;
         addr_q  <= '0;
         so_q    <= 1'b0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         ld_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         addr_q  <= addr_d;
         so_q    <= so_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         ld_q    <= ld_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      rx_d    = rx_q;
      tx_d    = ld_q ? mem_rdata : tx_q;
      addr_d  = addr_q;
      so_d    = so_q;
      oe_d    = oe_q;
      busy_d  = busy_q;
      err_d   = 1'b0;
      ld_d    = 1'b0;
      we      = 1'b0;
      if (ce_rise) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         oe_d    = 1'b0;
         so_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (ce_fall) begin
               state_d = CMD;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
            CMD: if (s_rise) begin
               rx_d  = rx_nxt;
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'd7) begin
                  cnt_d   = '0;
                  cmd_d   = rx_nxt;
                  state_d = cmd_valid(rx_nxt) ? ADDR : IGNORE;
                  err_d   = !cmd_valid(rx_nxt);
               end
            end
            ADDR: if (s_rise) begin
               addr_d = {addr_q[AW-2:0], si_s};
               cnt_d  = cnt_q + 8'd1;
               if (cnt_q == 8'(ADDR_BITS - 1)) begin
                  cnt_d   = '0;
                  state_d = cmd_q == CMD_READ ? RDATA : cmd_q == CMD_FAST_READ ? WAIT : WDATA;
                  ld_d    = cmd_q == CMD_READ;
               end
            end
            WAIT: if (s_rise) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'(FAST_WAIT - 1)) begin
                  cnt_d   = '0;
                  state_d = RDATA;
                  ld_d    = 1'b1;
               end
            end
            RDATA: begin
               if (s_fall) begin
                  so_d = tx_q[7];
                  oe_d = 1'b1;
                  tx_d = {tx_q[6:0], 1'b0};
               end
               // prefetch the next byte on the last sampling edge of the current one
               if (s_rise) begin
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_q == 8'd7) begin
                     cnt_d  = '0;
                     addr_d = addr_q + 1'b1;
                     ld_d   = 1'b1;
                  end
               end
            end
            WDATA: if (s_rise) begin
               rx_d  = rx_nxt;
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'd7) begin
                  cnt_d  = '0;
                  we     = 1'b1;
                  addr_d = addr_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
   // reads look ahead at addr_d so the data lands one clk after the address settles
   assign mem_addr = we ? addr_q : addr_d;
   psram_resp_mem #(.AW(AW)) u_mem (
      .clk    (clk),
      .we_i   (we),
      .addr_i (mem_addr),
      .wdata_i(rx_nxt),
      .rdata_o(mem_rdata)
   );
   assign bus.so    = so_q;
   assign bus.so_oe = oe_q;
   assign busy      = busy_q;
   assign cmd_err   = err_q;
endmodule
